multicycle_alu: RTL
===================

# multicycle_alu

Parametrised, registered successor to the combinational datapath ALU. It executes the same 4-bit opcode set plus an iterative multiply. Operands arrive and results leave through valid/ready handshakes, and results and flags are registered. It sits between the decode/register-read stage and writeback, and lets the control unit stall on a busy ALU or a back-pressured writeback.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, at least 8
- SHW, $clog2(WIDTH), shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  ALU can accept a bundle this cycle
- op  in  4  operation code
- a  in  WIDTH  operand 1; signed for sra/srav and overflow
- b  in  WIDTH  operand 2
- shamt  in  SHW  immediate shift amount
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  carry-out (add/sub), else 0
- overflow  out  1  signed overflow (add/sub), else 0
- busy  out  1  multiply in progress

## Operation
- Opcodes:
  - 0000 add a+b
  - 0001 negate (~a+1)
  - 0010 sub a+~b+1
  - 0011 and
  - 0100 xor
  - 0101 sll a by shamt
  - 0110 srl a by shamt
  - 0111 sra a by shamt
  - 1000 srl a by b[SHW-1:0]
  - 1001 sll a by b[SHW-1:0]
  - 1010 sra a by b[SHW-1:0]
  - 1011 mul, low WIDTH bits of a*b (unsigned shift-add)
  - 1100-1111: result 0, zero=1, other flags 0
- Carry = bit WIDTH of the (WIDTH+1)-bit sum; for sub this means carry=1 when no borrow (a>=b unsigned).
- Overflow = operand sign bits equal (after the b inversion for sub) and result sign differs. Negate reports carry and overflow 0.
- Flags are computed from the final result and registered together with it; they never change while out_valid=1.
- FSM states:
  - IDLE: accepts bundles.
  - MUL: iterative multiply. Holds acc (WIDTH), multiplicand (WIDTH, shifted left), multiplier (WIDTH, shifted right) and counter (SHW+1).
  - Each MUL cycle: if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - When counter reaches WIDTH: acc goes to result, out_valid=1, state returns to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at throughput 1.
- Accept occurs when in_valid && in_ready. Non-mul ops load result and flags at that edge. Mul enters MUL and latches operands.
- busy=1 exactly while state==MUL; in_ready=0 during MUL.
- result and flags stay stable while out_valid && !out_ready. out_valid clears on out_ready unless a new result loads in the same edge.

## Timing
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, result=0, zero=0, negative=0, carry=0, overflow=0, counter=0, busy=0. in_ready=1 in the first cycle after reset.
- Reset during MUL aborts the multiply. No result is produced.
- Single-cycle ops: accept at edge N, out_valid=1 after edge N (latency 1).
- Mul: accept at edge N, MUL runs edges N+1..N+WIDTH, out_valid=1 after edge N+WIDTH. Latency is WIDTH+1 edges (33 for WIDTH=32).
- Simultaneous out_ready and new accept: the old result retires, the new result loads, and out_valid stays 1.
- Mul completion while the previous result is still unconsumed cannot happen, because entry into MUL requires the output slot to be free or retiring.
- Shift by 0 returns a unchanged. Variable shifts use only b[SHW-1:0]; upper b bits are ignored.

## Test plan
- After reset, add a=0xFFFFFFFF, b=1 -> 1 cycle later: result=0, zero=1, carry=1, overflow=0, negative=0.
- add 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, negative=1, carry=0. Then sub 5-7 -> 0xFFFFFFFE, carry=0, negative=1.
- srav a=0x80000000, b=0xFFFFFF04 -> 0xF8000000. srl with shamt=31 on 0x80000000 -> 0x00000001. Opcode 1111 -> result 0, zero=1.
- mul 0x0000FFFF*0x00010001 -> busy=1 for 32 cycles, in_ready=0. result=0xFFFFFFFF appears exactly 33 edges after accept.
- Back-pressure: hold out_ready=0 for 5 cycles after an and-op -> result and flags stable, in_ready=0. Then pulse out_ready with in_valid high -> new result loads on the same edge, out_valid stays 1.
- Assert rst at MUL cycle 10 -> next cycle: out_valid=0, busy=0, in_ready=1, result=0. A subsequent add 2+3 -> result 5.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier that occupies the unit for WIDTH cycles.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NEG  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SRLV = 4'b1000;
  localparam logic [3:0] OP_SLLV = 4'b1001;
  localparam logic [3:0] OP_SRAV = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW:0]     CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0]     CNT_LAST = (SHW+1)'(WIDTH - 1);

  // Single-cycle opcode evaluation; returns {carry, overflow, result}.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [3:0]       f_op,
    input logic [WIDTH-1:0] f_a,
    input logic [WIDTH-1:0] f_b,
    input logic [SHW-1:0]   f_sh
  );
    logic [WIDTH:0]          sum;
    logic [WIDTH-1:0]        opb;
    logic [WIDTH-1:0]        res;
    logic signed [WIDTH-1:0] sa;
    logic                    is_sub;
    logic                    c;
    logic                    v;
    logic [SHW-1:0]          vsh;
    sa     = f_a;
    vsh    = f_b[SHW-1:0];
    is_sub = (f_op == OP_SUB);
    opb    = is_sub ? ~f_b : f_b;
    sum    = {1'b0, f_a} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
    res    = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (f_op)
      OP_ADD, OP_SUB: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (f_a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != f_a[WIDTH-1]);
      end
      OP_NEG:  res = ~f_a + ONE;
      OP_AND:  res = f_a & f_b;
      OP_XOR:  res = f_a ^ f_b;
      OP_SLL:  res = f_a << f_sh;
      OP_SRL:  res = f_a >> f_sh;
      OP_SRA:  res = sa >>> f_sh;
      OP_SRLV: res = f_a >> vsh;
      OP_SLLV: res = f_a << vsh;
      OP_SRAV: res = sa >>> vsh;
      default: res = '0;
    endcase
    return {c, v, res};
  endfunction

  // Zero/negative derived from whatever value is about to be registered.
  function automatic logic [1:0] result_flags(input logic [WIDTH-1:0] f_r);
    return {(f_r == '0), f_r[WIDTH-1]};
  endfunction

  logic [0:0]       r_state;
  logic [SHW:0]     r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_accept_mul;
  logic             w_accept_alu;
  logic [WIDTH+1:0] w_eval;
  logic [1:0]       w_eval_flags;
  logic [WIDTH-1:0] w_acc_next;
  logic [1:0]       w_mul_flags;
  logic             w_mul_done;

  always_comb begin
    w_in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    w_accept     = in_valid && w_in_ready;
    w_accept_mul = w_accept && (op == OP_MUL);
    w_accept_alu = w_accept && (op != OP_MUL);
    w_eval       = alu_eval(op, a, b, shamt);
    w_eval_flags = result_flags(w_eval[WIDTH-1:0]);
    w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mul_flags  = result_flags(w_acc_next);
    w_mul_done   = (r_state == ST_MUL) && (r_cnt == CNT_LAST);
  end

  // Control: FSM state, iteration counter and output-slot occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (out_ready) r_out_valid <= 1'b0;
          if (w_accept_mul) begin
            r_state <= ST_MUL;
            r_cnt   <= '0;
          end else if (w_accept_alu) begin
            r_out_valid <= 1'b1;
          end
        end
        ST_MUL: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_mul_done) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Multiplier datapath: operands latch on accept, then shift once per cycle.
  always_ff @(posedge clk) begin
    if (w_accept_mul) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Output register: loads only when the slot is free or retiring.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept_alu) begin
      r_result   <= w_eval[WIDTH-1:0];
      r_zero     <= w_eval_flags[1];
      r_negative <= w_eval_flags[0];
      r_carry    <= w_eval[WIDTH+1];
      r_overflow <= w_eval[WIDTH];
    end else if (w_mul_done) begin
      r_result   <= w_acc_next;
      r_zero     <= w_mul_flags[1];
      r_negative <= w_mul_flags[0];
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign busy      = (r_state == ST_MUL);

endmodule
